cla_multiword_sequencer: RTL and testbench

Multi-cycle add/subtract engine that time-multiplexes one narrow carry-lookahead adder across a wide operand. A WIDTH-bit operation is processed in CHUNK-bit slices, least-significant first, with the inter-slice carry held in a register. Operands enter through a valid/ready handshake and results leave through one. The block sits between the operand-issue logic and any consumer that can tolerate NCHUNK+1 cycles of latency in exchange for a small adder.

---
 rtl/cla_pkg.sv | 13 +
 rtl/carry_lookahead_adder.sv | 31 +++
 rtl/cla_multiword_sequencer.sv | 107 ++++++++++
 tb/tb_cla_multiword_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and default sizing for the multi-word carry-lookahead sequencer.
package cla_pkg;

   localparam int unsigned CLA_CHUNK_DEFAULT = 16;
   localparam int unsigned CLA_WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cla_seq_state_t;

endpackage : cla_pkg

// File: rtl/carry_lookahead_adder.sv
// Single-cycle carry-lookahead adder built from per-bit generate/propagate terms.
module carry_lookahead_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Carry into bit i+1 is generated at i, or propagated through i from below.
   always_comb begin
      carry    = '0;
      carry[0] = carry_in;
      for (int i = 0; i < int'(WIDTH); i++) begin
         carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
   end

   assign sum       = prop ^ carry[WIDTH-1:0];
   assign carry_out = carry[WIDTH];

endmodule : carry_lookahead_adder

// File: rtl/cla_multiword_sequencer.sv
// Wide add/subtract that reuses one CHUNK-bit adder across NCHUNK cycles,
// least-significant slice first, with the inter-slice carry kept in a register.
module cla_multiword_sequencer
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH_DEFAULT,
   parameter int unsigned CHUNK = CLA_CHUNK_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (((WIDTH % CHUNK) != 0) || (NCHUNK < 2)) begin : g_bad_cfg
      $error("cla_multiword_sequencer: WIDTH must be a multiple of CHUNK with at least 2 slices");
   end

   cla_seq_state_t               state_q;
   logic [NCHUNK-1:0][CHUNK-1:0] a_q;
   logic [NCHUNK-1:0][CHUNK-1:0] b_q;
   logic [NCHUNK-1:0][CHUNK-1:0] sum_q;
   logic [IDXW-1:0]              idx_q;
   logic                         carry_q;

   logic [CHUNK-1:0] slice_sum;
   logic             slice_cout;
   logic             last_slice;

   carry_lookahead_adder #(
      .WIDTH (CHUNK)
   ) u_adder (
      .a         (a_q[idx_q]),
      .b         (b_q[idx_q]),
      .carry_in  (carry_q),
      .sum       (slice_sum),
      .carry_out (slice_cout)
   );

   assign last_slice = (idx_q == IDXW'(NCHUNK - 1));
   assign out_sum    = sum_q;

   // Sequencer: b is stored pre-inverted for subtract so the adder only ever adds.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= in_a;
                  b_q      <= in_b ^ {WIDTH{in_sub}};
                  carry_q  <= in_sub;
                  idx_q    <= '0;
                  in_ready <= 1'b0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               sum_q[idx_q] <= slice_sum;
               carry_q      <= slice_cout;
               idx_q        <= idx_q + IDXW'(1);
               if (last_slice) begin
                  out_carry <= slice_cout;
                  out_ovf   <= (a_q[NCHUNK-1][CHUNK-1] == b_q[NCHUNK-1][CHUNK-1]) &&
                               (slice_sum[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
                  out_valid <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : cla_multiword_sequencer

// File: tb/tb_cla_multiword_sequencer.sv
// Self-checking bench: directed vector table, handshake corner sequences and
// randomized operations against a signed/unsigned arithmetic reference model.
module tb_cla_multiword_sequencer;

   localparam int unsigned W = 64;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_carry;
   logic         out_ovf;

   int total_cnt = 0;
   int pass_cnt  = 0;

   cla_multiword_sequencer #(
      .WIDTH (64),
      .CHUNK (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
   } vec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: exact integer arithmetic, then reduce to the 64-bit view.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic c, output logic v);
      logic signed [W+1:0] sa, sb, r;
      logic [W:0]          u;
      sa = $signed({{2{a[W-1]}}, a});
      sb = $signed({{2{b[W-1]}}, b});
      r  = sub ? (sa - sb) : (sa + sb);
      s  = r[W-1:0];
      v  = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
      u  = {1'b0, a} + {1'b0, b};
      c  = sub ? (a >= b) : u[W];
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      chk("in_ready_at_offer", W'(in_ready), W'(1));
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Called in cycle 1 after accept; returns the cycle in which out_valid rose.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      if (!out_valid) chk("out_valid_timeout", W'(out_valid), W'(1));
   endtask

   task automatic drain;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic [W-1:0] es, input logic ec,
                                input logic ev, input bit check_lat);
      int lat;
      offer(a, b, sub);
      wait_valid(lat);
      if (check_lat) chk({tag, "_latency"}, W'(lat), W'(5));
      chk({tag, "_sum"},   out_sum,        es);
      chk({tag, "_carry"}, W'(out_carry), W'(ec));
      chk({tag, "_ovf"},   W'(out_ovf),   W'(ev));
      drain();
   endtask

   vec_t vecs[7];

   initial begin
      logic [W-1:0] ra, rb, es, held;
      logic         rs, ec, ev;
      int           lat;

      vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[3] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
      vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_sub = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("rst_in_ready",  W'(in_ready),  W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_sum",   out_sum,       W'(0));
      chk("rst_out_carry", W'(out_carry), W'(0));
      chk("rst_out_ovf",   W'(out_ovf),   W'(0));

      for (int i = 0; i < 7; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                       vecs[i].sum, vecs[i].carry, vecs[i].ovf, 1'b1);
      chk("back_to_back_ready", W'(in_ready), W'(1));

      // Backpressure: result holds while new operands are offered in DONE.
      offer(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
      wait_valid(lat);
      held     = out_sum;
      chk("bp_first_sum", held, 64'h1234_5678_9ABC_DF00);
      in_a     = 64'h0000_0000_FFFF_FFFF;
      in_b     = 64'h0000_0000_0000_0001;
      in_sub   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("bp_valid_%0d", i), W'(out_valid), W'(1));
         chk($sformatf("bp_ready_%0d", i), W'(in_ready),  W'(0));
         chk($sformatf("bp_sum_%0d", i),   out_sum,       held);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_ready_after_hs", W'(in_ready),  W'(1));
      chk("bp_valid_after_hs", W'(out_valid), W'(0));
      step();
      in_valid = 1'b0;
      chk("bp_accepted", W'(in_ready), W'(0));
      wait_valid(lat);
      chk("bp_second_latency", W'(lat), W'(5));
      chk("bp_second_sum", out_sum, 64'h0000_0001_0000_0000);
      drain();

      // Reset during the second RUN cycle discards the operation.
      offer(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_in_ready",  W'(in_ready),  W'(1));
      chk("mid_rst_out_valid", W'(out_valid), W'(0));
      chk("mid_rst_out_sum",   out_sum,       W'(0));
      chk("mid_rst_out_carry", W'(out_carry), W'(0));
      chk("mid_rst_out_ovf",   W'(out_ovf),   W'(0));
      run_and_check("post_rst", 64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0, 1'b1);

      // Randomized operations, occasionally with a random consumer stall.
      for (int n = 0; n < 40; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rs = 1'($urandom_range(0, 1));
         if (n % 8 == 0) rb = ~ra;
         if (n % 8 == 1) rb = ra;
         model(ra, rb, rs, es, ec, ev);
         offer(ra, rb, rs);
         wait_valid(lat);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
         chk($sformatf("rnd%0d_sum", n),   out_sum,        es);
         chk($sformatf("rnd%0d_carry", n), W'(out_carry), W'(ec));
         chk($sformatf("rnd%0d_ovf", n),   W'(out_ovf),   W'(ev));
         drain();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_cla_multiword_sequencer
